// File: rtl/msp_inst_encoder.sv
// -----------------------------------------------------------------------------
// msp_inst_encoder
// Purpose : MSP430 instruction encoder, the inverse of the core debug decoder.
//           Takes one instruction as fields and emits its 1-3 word machine
//           code stream (opcode, source ext, destination ext) over a
//           valid/ready word port. Each word is tagged with its program
//           address.
// Ports   :
//   mclk, puc_rst       clock and synchronous active-high reset
//   req_valid/ready     instruction request handshake; ready only when idle
//   req_type            0=SIG-OP 1=JUMP 2=TWO-OP 3=illegal
//   req_op              TWO-OP opcode[15:12]; SIG-OP op[2:0]; JUMP cond[2:0]
//   req_bw/src/as       byte flag, source register, source addressing mode
//   req_dst/ad          destination register and mode (TWO-OP only)
//   req_src_ext/dst_ext extension words; req_jmp_off signed word offset
//   word_valid/ready    encoded word handshake
//   word_data/addr/last encoded word, its program address, final-word flag
//   err                 one-cycle pulse when an illegal request is dropped
//   inst_count          legal instructions fully emitted (wraps)
//   word_count          words transferred (wraps)
// -----------------------------------------------------------------------------
module msp_inst_encoder #(
  parameter logic [15:0] PC_INIT = 16'hF800,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             mclk,
  input  logic             puc_rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_type,
  input  logic [3:0]       req_op,
  input  logic             req_bw,
  input  logic [3:0]       req_src,
  input  logic [1:0]       req_as,
  input  logic [3:0]       req_dst,
  input  logic             req_ad,
  input  logic [15:0]      req_src_ext,
  input  logic [15:0]      req_dst_ext,
  input  logic [9:0]       req_jmp_off,
  output logic             word_valid,
  input  logic             word_ready,
  output logic [15:0]      word_data,
  output logic [15:0]      word_addr,
  output logic             word_last,
  output logic             err,
  output logic [CNT_W-1:0] inst_count,
  output logic [CNT_W-1:0] word_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OP   = 2'd1;
  localparam logic [1:0] ST_SEXT = 2'd2;
  localparam logic [1:0] ST_DEXT = 2'd3;

  localparam logic [1:0] T_SIG = 2'd0;
  localparam logic [1:0] T_JMP = 2'd1;
  localparam logic [1:0] T_TWO = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Opcode word for a legal request; illegal types encode to zero (never emitted).
  function automatic logic [15:0] encode_opword(
    input logic [1:0] typ,
    input logic [3:0] op,
    input logic       bw,
    input logic [3:0] src,
    input logic [1:0] as_m,
    input logic [3:0] dst,
    input logic       ad,
    input logic [9:0] off
  );
    logic [15:0] w;
    case (typ)
      T_TWO:   w = {op, src, ad, bw, as_m, dst};
      T_SIG:   w = {6'b000100, op[2:0], bw, as_m, src};
      T_JMP:   w = {3'b001, op[2:0], off};
      default: w = 16'h0000;
    endcase
    return w;
  endfunction

  logic [1:0]       state_q, state_d;
  logic             req_ready_q, req_ready_d;
  logic             word_valid_q, word_valid_d;
  logic [15:0]      word_data_q, word_data_d;
  logic [15:0]      word_addr_q, word_addr_d;
  logic             word_last_q, word_last_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] inst_count_q, inst_count_d;
  logic [CNT_W-1:0] word_count_q, word_count_d;
  logic [15:0]      sext_q, sext_d;
  logic [15:0]      dext_q, dext_d;
  logic             need_sext_q, need_sext_d;
  logic             need_dext_q, need_dext_d;

  logic             legal_s;
  logic             need_sext_s;
  logic             need_dext_s;
  logic [15:0]      opword_s;

  // Request decode: legality, extension-word needs and opcode word.
  always_comb begin
    legal_s = 1'b0;
    case (req_type)
      T_SIG:   legal_s = (req_op <= 4'd6);
      T_JMP:   legal_s = 1'b1;
      T_TWO:   legal_s = (req_op >= 4'd4);
      default: legal_s = 1'b0;
    endcase
    // R3 in any mode and R2 in modes 10/11 are constant generators: no ext word.
    need_sext_s = (req_type != T_JMP) &&
                  (((req_as == 2'b01) && (req_src != 4'd3)) ||
                   ((req_as == 2'b11) && (req_src == 4'd0)));
    need_dext_s = (req_type == T_TWO) && req_ad;
    opword_s    = encode_opword(req_type, req_op, req_bw, req_src, req_as,
                                req_dst, req_ad, req_jmp_off);
  end

  // Next-state logic for the emit FSM, word port and counters.
  always_comb begin
    state_d      = state_q;
    req_ready_d  = req_ready_q;
    word_valid_d = word_valid_q;
    word_data_d  = word_data_q;
    word_addr_d  = word_addr_q;
    word_last_d  = word_last_q;
    err_d        = 1'b0;
    inst_count_d = inst_count_q;
    word_count_d = word_count_q;
    sext_d       = sext_q;
    dext_d       = dext_q;
    need_sext_d  = need_sext_q;
    need_dext_d  = need_dext_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          if (legal_s) begin
            state_d      = ST_OP;
            req_ready_d  = 1'b0;
            word_valid_d = 1'b1;
            word_data_d  = opword_s;
            word_last_d  = !(need_sext_s || need_dext_s);
            sext_d       = req_src_ext;
            dext_d       = req_dst_ext;
            need_sext_d  = need_sext_s;
            need_dext_d  = need_dext_s;
          end else begin
            // Illegal request: dropped, flagged, no words emitted.
            err_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_OP, ST_SEXT, ST_DEXT: begin
        if (word_valid_q && word_ready) begin
          word_addr_d  = word_addr_q + 16'd2;
          word_count_d = word_count_q + CNT_ONE;
          if (word_last_q) begin
            state_d      = ST_IDLE;
            req_ready_d  = 1'b1;
            word_valid_d = 1'b0;
            word_last_d  = 1'b0;
            inst_count_d = inst_count_q + CNT_ONE;
          end else if ((state_q == ST_OP) && need_sext_q) begin
            state_d     = ST_SEXT;
            word_data_d = sext_q;
            word_last_d = !need_dext_q;
          end else begin
            state_d     = ST_DEXT;
            word_data_d = dext_q;
            word_last_d = 1'b1;
          end
        end else begin
          // Sink stalled: hold data/addr/last.
          state_d = state_q;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        req_ready_d  = 1'b1;
        word_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      state_q      <= ST_IDLE;
      req_ready_q  <= 1'b1;
      word_valid_q <= 1'b0;
      word_data_q  <= 16'h0000;
      word_addr_q  <= PC_INIT;
      word_last_q  <= 1'b0;
      err_q        <= 1'b0;
      inst_count_q <= {CNT_W{1'b0}};
      word_count_q <= {CNT_W{1'b0}};
      sext_q       <= 16'h0000;
      dext_q       <= 16'h0000;
      need_sext_q  <= 1'b0;
      need_dext_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      word_valid_q <= word_valid_d;
      word_data_q  <= word_data_d;
      word_addr_q  <= word_addr_d;
      word_last_q  <= word_last_d;
      err_q        <= err_d;
      inst_count_q <= inst_count_d;
      word_count_q <= word_count_d;
      sext_q       <= sext_d;
      dext_q       <= dext_d;
      need_sext_q  <= need_sext_d;
      need_dext_q  <= need_dext_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign word_valid = word_valid_q;
  assign word_data  = word_data_q;
  assign word_addr  = word_addr_q;
  assign word_last  = word_last_q;
  assign err        = err_q;
  assign inst_count = inst_count_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_msp_inst_encoder.sv
// -----------------------------------------------------------------------------
// tb_msp_inst_encoder
// Purpose : self-checking bench for msp_inst_encoder. A driver issues
//           instructions and pushes the expected word stream into a queue;
//           a monitor pops and compares on each word transfer, and also
//           checks err pulses, counters and hold-while-stalled behaviour.
// -----------------------------------------------------------------------------
module tb_msp_inst_encoder;

  logic        mclk = 1'b0;
  logic        puc_rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_type = 2'd0;
  logic [3:0]  req_op = 4'd0;
  logic        req_bw = 1'b0;
  logic [3:0]  req_src = 4'd0;
  logic [1:0]  req_as = 2'd0;
  logic [3:0]  req_dst = 4'd0;
  logic        req_ad = 1'b0;
  logic [15:0] req_src_ext = 16'h0000;
  logic [15:0] req_dst_ext = 16'h0000;
  logic [9:0]  req_jmp_off = 10'd0;
  logic        word_valid;
  logic        word_ready = 1'b1;
  logic [15:0] word_data;
  logic [15:0] word_addr;
  logic        word_last;
  logic        err;
  logic [31:0] inst_count;
  logic [31:0] word_count;

  msp_inst_encoder dut (
    .mclk(mclk), .puc_rst(puc_rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_type(req_type), .req_op(req_op), .req_bw(req_bw),
    .req_src(req_src), .req_as(req_as), .req_dst(req_dst), .req_ad(req_ad),
    .req_src_ext(req_src_ext), .req_dst_ext(req_dst_ext), .req_jmp_off(req_jmp_off),
    .word_valid(word_valid), .word_ready(word_ready),
    .word_data(word_data), .word_addr(word_addr), .word_last(word_last),
    .err(err), .inst_count(inst_count), .word_count(word_count)
  );

  always #5 mclk = ~mclk;

  typedef struct packed {
    logic [15:0] data;
    logic [15:0] addr;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          rdy_mode = 0;      // 0 always ready, 1 random, 2 stalled
  logic [15:0] exp_pc = 16'hF800;
  bit          wrapped = 1'b0;
  int          words_issued = 0;
  int          legal_issued = 0;
  int          err_seen = 0;
  int          m_words = 0;
  int          m_insts = 0;

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic bit is_illegal(input int t, input int op);
    return (t == 3) || (t == 2 && op < 4) || (t == 0 && op > 6);
  endfunction

  // Reference encoder: plain arithmetic on field values.
  function automatic int model(input int t, input int op, input int bw, input int src,
                               input int as_m, input int dst, input int ad,
                               input logic [15:0] sx, input logic [15:0] dx, input int off,
                               output logic [15:0] w0, output logic [15:0] w1,
                               output logic [15:0] w2);
    logic [15:0] w[3];
    int n;
    w[0] = 16'h0; w[1] = 16'h0; w[2] = 16'h0;
    n = 0;
    if (!is_illegal(t, op)) begin
      if (t == 2)      w[0] = 16'(op * 4096 + src * 256 + ad * 128 + bw * 64 + as_m * 16 + dst);
      else if (t == 0) w[0] = 16'(4096 + (op % 8) * 128 + bw * 64 + as_m * 16 + src);
      else             w[0] = 16'(8192 + (op % 8) * 1024 + off);
      n = 1;
      if (t != 1 && ((as_m == 1 && src != 3) || (as_m == 3 && src == 0))) begin
        w[n] = sx; n++;
      end
      if (t == 2 && ad == 1) begin
        w[n] = dx; n++;
      end
    end
    w0 = w[0]; w1 = w[1]; w2 = w[2];
    return n;
  endfunction

  task automatic push_words(input int n, input logic [15:0] w0, input logic [15:0] w1,
                            input logic [15:0] w2);
    logic [15:0] w[3];
    exp_t e;
    w[0] = w0; w[1] = w1; w[2] = w2;
    for (int i = 0; i < n; i++) begin
      e.data = w[i];
      e.addr = exp_pc;
      e.last = (i == n - 1);
      exp_q.push_back(e);
      exp_pc = exp_pc + 16'd2;
      if (exp_pc == 16'h0000) wrapped = 1'b1;
      words_issued++;
    end
    if (n > 0) legal_issued++;
  endtask

  task automatic drive(input int t, input int op, input int bw, input int src, input int as_m,
                       input int dst, input int ad, input logic [15:0] sx,
                       input logic [15:0] dx, input int off, output bit acc);
    @(posedge mclk); #1;
    req_type = 2'(t); req_op = 4'(op); req_bw = 1'(bw); req_src = 4'(src);
    req_as = 2'(as_m); req_dst = 4'(dst); req_ad = 1'(ad);
    req_src_ext = sx; req_dst_ext = dx; req_jmp_off = 10'(off);
    req_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge mclk);
      if (req_ready) begin
        acc = 1'b1;
        break;
      end
    end
    if (!acc) chk(1'b0, "req_accept_timeout", 32'd0, 32'd1);
    @(posedge mclk); #1;
    req_valid = 1'b0;
    // Junk on the fields while idle-invalid or busy: must be ignored.
    req_type = 2'($urandom); req_op = 4'($urandom); req_src_ext = 16'($urandom);
  endtask

  task automatic send_exp(input int t, input int op, input int bw, input int src, input int as_m,
                          input int dst, input int ad, input logic [15:0] sx,
                          input logic [15:0] dx, input int off, input int n,
                          input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2);
    bit acc;
    drive(t, op, bw, src, as_m, dst, ad, sx, dx, off, acc);
    if (acc) push_words(n, w0, w1, w2);
  endtask

  task automatic do_reset();
    @(posedge mclk); #1;
    puc_rst = 1'b1;
    exp_pc = 16'hF800;
    words_issued = 0;
    legal_issued = 0;
    @(posedge mclk); #1;
    puc_rst = 1'b0;
  endtask

  // Sink-side ready generator.
  always @(posedge mclk) begin
    #1;
    case (rdy_mode)
      0:       word_ready = 1'b1;
      1:       word_ready = ($urandom_range(0, 3) != 0);
      default: word_ready = 1'b0;
    endcase
  end

  // Monitor: scoreboard pops, err timing, counters, stall stability.
  bit          exp_err = 1'b0;
  bit          prev_stall = 1'b0;
  logic [15:0] prev_data, prev_addr;
  logic        prev_last;
  always @(negedge mclk) begin
    exp_t e;
    if (puc_rst) begin
      exp_q.delete();
      m_words = 0;
      m_insts = 0;
      exp_err = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (err) err_seen++;
      if (err || exp_err) chk(err == exp_err, "err_pulse", 32'(err), 32'(exp_err));
      exp_err = req_valid && req_ready && is_illegal(int'(req_type), int'(req_op));
      chk(word_count == 32'(m_words), "word_count", word_count, 32'(m_words));
      chk(inst_count == 32'(m_insts), "inst_count", inst_count, 32'(m_insts));
      if (prev_stall) begin
        chk(word_valid == 1'b1, "stall_valid", 32'(word_valid), 32'd1);
        chk(word_data == prev_data, "stall_data", 32'(word_data), 32'(prev_data));
        chk(word_addr == prev_addr, "stall_addr", 32'(word_addr), 32'(prev_addr));
        chk(word_last == prev_last, "stall_last", 32'(word_last), 32'(prev_last));
      end
      if (word_valid) begin
        chk(req_ready == 1'b0, "ready_while_busy", 32'(req_ready), 32'd0);
        if (exp_q.size() == 0) begin
          chk(1'b0, "spurious_word", 32'(word_data), 32'd0);
        end else if (word_ready) begin
          e = exp_q.pop_front();
          chk(word_data == e.data, "word_data", 32'(word_data), 32'(e.data));
          chk(word_addr == e.addr, "word_addr", 32'(word_addr), 32'(e.addr));
          chk(word_last == e.last, "word_last", 32'(word_last), 32'(e.last));
          m_words++;
          if (e.last) m_insts++;
        end
      end
      prev_stall = word_valid && !word_ready;
      prev_data  = word_data;
      prev_addr  = word_addr;
      prev_last  = word_last;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge mclk);
      if (exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk(1'b0, "drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge mclk);
  endtask

  initial begin
    bit acc;
    int t, op, n, e0;
    logic [31:0] wc0;
    logic [15:0] w0, w1, w2, sx, dx;

    repeat (3) @(posedge mclk);
    #1 puc_rst = 1'b0;
    @(negedge mclk);
    chk(req_ready == 1'b1, "rst_req_ready", 32'(req_ready), 32'd1);
    chk(word_valid == 1'b0, "rst_word_valid", 32'(word_valid), 32'd0);
    chk(word_data == 16'h0000, "rst_word_data", 32'(word_data), 32'd0);
    chk(word_addr == 16'hF800, "rst_word_addr", 32'(word_addr), 32'hF800);
    chk(word_last == 1'b0, "rst_word_last", 32'(word_last), 32'd0);
    chk(err == 1'b0, "rst_err", 32'(err), 32'd0);

    // Directed vectors.
    send_exp(2, 4, 0, 0, 3, 2, 1, 16'h1234, 16'h0200, 0, 3, 16'h40B2, 16'h1234, 16'h0200);
    send_exp(2, 4, 0, 3, 0, 3, 0, 16'hAAAA, 16'h5555, 0, 1, 16'h4303, 16'h0, 16'h0);
    send_exp(2, 5, 0, 2, 2, 10, 0, 16'hAAAA, 16'h5555, 0, 1, 16'h522A, 16'h0, 16'h0);
    send_exp(1, 7, 0, 0, 0, 0, 0, 16'hAAAA, 16'h5555, 10'h3FF, 1, 16'h3FFF, 16'h0, 16'h0);
    send_exp(0, 4, 1, 5, 1, 0, 0, 16'h0010, 16'h5555, 0, 2, 16'h1255, 16'h0010, 16'h0);
    drain();

    // Sink stall mid-stream.
    rdy_mode = 2;
    wc0 = word_count;
    send_exp(2, 4, 0, 0, 3, 2, 1, 16'hBEEF, 16'hCAFE, 0, 3, 16'h40B2, 16'hBEEF, 16'hCAFE);
    repeat (3) @(negedge mclk);
    chk(word_valid == 1'b1, "stall_hold_valid", 32'(word_valid), 32'd1);
    chk(word_count == wc0, "stall_no_count", word_count, wc0);
    rdy_mode = 0;
    drain();

    // Illegal TWO-OP op=2.
    e0 = err_seen;
    wc0 = inst_count;
    send_exp(2, 2, 0, 4, 0, 5, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 16'h0);
    repeat (3) @(negedge mclk);
    chk(err_seen == e0 + 1, "illegal_err_count", 32'(err_seen), 32'(e0 + 1));
    chk(inst_count == wc0, "illegal_no_inst", inst_count, wc0);

    // Randomised instructions against the reference model.
    for (int k = 0; k < 300; k++) begin
      n = $urandom_range(0, 9);
      t = (n < 3) ? 0 : (n < 5) ? 1 : (n < 9) ? 2 : 3;
      op = (t == 0) ? $urandom_range(0, 7) : $urandom_range(0, 15);
      rdy_mode = $urandom_range(0, 1);
      sx = 16'($urandom); dx = 16'($urandom);
      begin
        int bw, src, as_m, dst, ad, off;
        bw = $urandom_range(0, 1); src = $urandom_range(0, 15); as_m = $urandom_range(0, 3);
        dst = $urandom_range(0, 15); ad = $urandom_range(0, 1); off = $urandom_range(0, 1023);
        n = model(t, op, bw, src, as_m, dst, ad, sx, dx, off, w0, w1, w2);
        drive(t, op, bw, src, as_m, dst, ad, sx, dx, off, acc);
        if (acc) push_words(n, w0, w1, w2);
      end
    end

    // Keep emitting NOPs until the address wraps FFFE -> 0000.
    rdy_mode = 0;
    for (int k = 0; k < 1200 && !wrapped; k++)
      send_exp(2, 4, 0, 3, 0, 3, 0, 16'h0, 16'h0, 0, 1, 16'h4303, 16'h0, 16'h0);
    send_exp(2, 4, 0, 3, 0, 3, 0, 16'h0, 16'h0, 0, 1, 16'h4303, 16'h0, 16'h0);
    chk(wrapped, "addr_wrapped", 32'(wrapped), 32'd1);
    drain();
    chk(inst_count == 32'(legal_issued), "final_inst_count", inst_count, 32'(legal_issued));
    chk(word_count == 32'(words_issued), "final_word_count", word_count, 32'(words_issued));

    // Reset after first word of a 3-word instruction.
    do_reset();
    rdy_mode = 0;
    send_exp(2, 4, 0, 0, 3, 2, 1, 16'h1234, 16'h0200, 0, 3, 16'h40B2, 16'h1234, 16'h0200);
    acc = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge mclk);
      if (word_valid && word_ready) begin
        acc = 1'b1;
        break;
      end
    end
    chk(acc, "first_word_seen", 32'(acc), 32'd1);
    @(posedge mclk); #1 puc_rst = 1'b1;
    @(posedge mclk); #1 puc_rst = 1'b0;
    @(negedge mclk);
    chk(word_valid == 1'b0, "midrst_valid", 32'(word_valid), 32'd0);
    chk(word_addr == 16'hF800, "midrst_addr", 32'(word_addr), 32'hF800);
    chk(inst_count == 32'd0, "midrst_inst", inst_count, 32'd0);
    chk(word_count == 32'd0, "midrst_words", word_count, 32'd0);
    chk(req_ready == 1'b1, "midrst_ready", 32'(req_ready), 32'd1);
    repeat (3) @(negedge mclk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
